// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud divisor and parity mode.
// Define UART_RX_PARITY_EN to add one even-parity bit after the data bits.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// Serial input and received-byte outputs of the UART byte receiver.
interface uart_byte_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;

    modport master (output rx, input data, rx_done, frame_err, parity_err);
    modport slave  (input rx, output data, rx_done, frame_err, parity_err);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line with 1->0 edge detection.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic rx_sync_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchroniser chain plus one delayed copy for edge detection; idle-high reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_sync_o = sync_q;
    assign fall_o    = prev_q & ~sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// UART byte receiver, 8N1; with UART_RX_PARITY_EN defined it expects 8E1 and
// reports parity mismatches on parity_err.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic          sclk,
    input  logic          rst,
    uart_byte_rx_if.slave bus
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int HALF_DIV = BAUD_DIV / 2;
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF_DIV - 1);
    // The edge reaches the FSM two cycles after the synchronised line fell.
    localparam logic [CNT_W-1:0] CNT_SEED = CNT_W'(2);

    localparam uart_state_e AFTER_DATA = PARITY_EN ? PARITY : STOP;

    logic             rx_sync_s;
    logic             fall_s;
    logic             sample_s;
    uart_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             rx_done_q;
    logic             frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q;
    logic             parity_err_q;
`endif

    uart_rx_sync u_sync (
        .clk_i     (sclk),
        .rst_i     (rst),
        .rx_i      (bus.rx),
        .rx_sync_o (rx_sync_s),
        .fall_o    (fall_s)
    );

    // Sample point: mid start bit in START, then one full bit period apart.
    always_comb begin
        case (state_q)
            START:               sample_s = (cnt_q >= CNT_MID);
            DATA, PARITY, STOP:  sample_s = (cnt_q == CNT_LAST);
            default:             sample_s = 1'b0;
        endcase
    end

    // Receive FSM with bit timing, shift register and registered status pulses.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (fall_s) begin
                        state_q <= START;
                        cnt_q   <= CNT_SEED;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    if (sample_s) begin
                        cnt_q <= '0;
                        bit_q <= 3'd0;
`ifdef UART_RX_PARITY_EN
                        par_bad_q <= 1'b0;
`endif
                        // A line already back high is a glitch, not a start bit.
                        state_q <= rx_sync_s ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (sample_s) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_s, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= AFTER_DATA;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample_s) begin
                        cnt_q     <= '0;
                        par_bad_q <= (rx_sync_s != even_parity(shift_q));
                        state_q   <= STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (sample_s) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (!rx_sync_s) begin
                            frame_err_q <= 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        else if (par_bad_q) begin
                            parity_err_q <= 1'b1;
                        end
`endif
                        else begin
                            data_q    <= shift_q;
                            rx_done_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, meaning system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115_200, meaning serial bit rate in bit/s.
REQ-003 The block SHALL have port sclk  input  1  meaning single system clock, all state on its rising edge.
REQ-004 The block SHALL have port rst  input  1  meaning reset, asynchronous, active-high.
REQ-005 The block SHALL have port rx  input  1  meaning asynchronous serial line, idle high.
REQ-006 The block SHALL have port data  output  8  meaning last correctly received byte.
REQ-007 The block SHALL have port rx_done  output  1  meaning one-cycle pulse, data valid and newly updated.
REQ-008 The block SHALL have port frame_err  output  1  meaning one-cycle pulse, stop bit sampled low.
REQ-009 The block SHALL have port parity_err  output  1  meaning one-cycle pulse, parity mismatch (tied 0 when parity compiled out).

Function
REQ-010 The block SHALL synchronise rx through two flip-flops and detect a start condition as a 1->0 transition of the synchronised signal.
REQ-011 The block SHALL use BAUD_DIV = CLK_FREQ/BAUD (integer division, 434 at defaults) and a bit counter wide enough for BAUD_DIV-1.
REQ-012 The block SHALL implement states IDLE, START, DATA, PARITY, STOP; IDLE->START on a detected falling edge, other states advance only on sample points.
REQ-013 In START the block SHALL sample at BAUD_DIV/2 cycles after the edge; low -> DATA, high -> IDLE with no output pulse (glitch rejection).
REQ-014 In DATA the block SHALL sample every BAUD_DIV cycles, 8 bits, LSB first, into a shift register.
REQ-015 In STOP the block SHALL sample at mid-bit; high -> load data, pulse rx_done one cycle; low -> pulse frame_err one cycle, data unchanged, no rx_done.
REQ-016 The block SHALL return to IDLE in the cycle after the stop-bit sample so a start bit beginning half a bit later is accepted (back-to-back bytes).
REQ-017 rx_done SHALL occur 9.5*BAUD_DIV +/-2 cycles after the rx falling edge (2-cycle synchroniser included).
REQ-018 An rx held low after a frame error SHALL not start a new frame until a fresh 1->0 transition is seen.
REQ-019 rx_done, frame_err and parity_err SHALL be mutually exclusive in any cycle.

Reset
REQ-020 While rst is high the block SHALL force IDLE, counters 0, synchroniser flops 1, data 8'h00, rx_done/frame_err/parity_err 0.
REQ-021 Reset asserted mid-frame SHALL abort the frame with no pulse; reception resumes on the next falling edge after rst deasserts.

Configuration
REQ-022 With macro UART_RX_PARITY_EN defined the block SHALL expect one even-parity bit after bit 7 (PARITY state); mismatch -> parity_err pulse, no rx_done, data unchanged, stop bit still consumed.
REQ-023 Without UART_RX_PARITY_EN the block SHALL skip PARITY (DATA->STOP) and drive parity_err constant 0.

Structure
REQ-024 A shared package uart_pkg SHALL hold the state enumeration, the BAUD_DIV computation function and the parity-mode constant, shared with the transmitter.
REQ-025 The two-flop synchroniser with edge detect SHALL be a sub-module named uart_rx_sync; everything else stays in uart_byte_rx.

Verification (CLK_FREQ=50_000_000, BAUD=115_200, BAUD_DIV=434)
REQ-026 Send 8'hAB 8N1 -> exactly one rx_done pulse, data=8'hAB, frame_err=0, latency within REQ-017.
REQ-027 Send AB CD 01 78 56 34 12 EF back-to-back with no idle gap -> eight rx_done pulses, data matching in order.
REQ-028 Pulse rx low for 100 cycles then high -> no rx_done, no frame_err, state IDLE.
REQ-029 Send 8'h55 with stop bit 0 after a good 8'h3C -> frame_err pulse, no rx_done, data stays 8'h3C.
REQ-030 Assert rst during bit 4 of 8'h3C -> all outputs 0, no pulse; subsequent 8'h3C received with data=8'h3C.
REQ-031 With UART_RX_PARITY_EN, send 8'h07 with parity bit 0 -> parity_err pulse, no rx_done; with parity bit 1 -> rx_done, data=8'h07.
